// File: rtl/stream_serializer_if.sv
// stream_serializer_if: upstream word and downstream beat handshakes of stream_serializer.
// o_data_last exists only when SERIALIZER_LAST_EN is defined.
interface stream_serializer_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  logic [IN_WIDTH-1:0] i_data;
  logic i_data_valid;
  logic o_data_ready;
  logic [OUT_WIDTH-1:0] o_data;
  logic o_data_valid;
  logic i_data_ready;
`ifdef SERIALIZER_LAST_EN
  logic o_data_last;
`endif
  modport master (
    output i_data, i_data_valid, i_data_ready,
`ifdef SERIALIZER_LAST_EN
    input o_data_last,
`endif
    input o_data_ready, o_data, o_data_valid
  );
  modport slave (
    input i_data, i_data_valid, i_data_ready,
`ifdef SERIALIZER_LAST_EN
    output o_data_last,
`endif
    output o_data_ready, o_data, o_data_valid
  );
endinterface

// File: rtl/stream_serializer.sv
// stream_serializer: valid/ready width-down converter, one IN_WIDTH word -> RATIO LSB-first beats.
// Define SERIALIZER_LAST_EN to add o_data_last marking the final beat of each word.
module stream_serializer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO = 4
) (
  input logic i_clock,
  input logic i_reset_n,
  stream_serializer_if.slave bus
);
  localparam int OUT_WIDTH = IN_WIDTH / RATIO;
  localparam int CW = $clog2(RATIO);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [IN_WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic last, in_fire, out_fire;
  // i_data_ready -> o_data_ready is the only combinational path through the block
  always_comb begin
    last = cnt == CW'(RATIO - 1);
    bus.o_data_ready = i_reset_n & ((state == IDLE) | (last & bus.i_data_ready));
    in_fire = bus.i_data_valid & bus.o_data_ready;
    out_fire = bus.o_data_valid & bus.i_data_ready;
  end
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bus.o_data <= '0;
      bus.o_data_valid <= 1'b0;
`ifdef SERIALIZER_LAST_EN
      bus.o_data_last <= 1'b0;
`endif
    end else if (in_fire) begin
      state <= SEND;
      sr <= bus.i_data;
      cnt <= '0;
      bus.o_data <= bus.i_data[OUT_WIDTH-1:0];
      bus.o_data_valid <= 1'b1;
`ifdef SERIALIZER_LAST_EN
      bus.o_data_last <= 1'b0;
`endif
    end else if (out_fire & last) begin
      state <= IDLE;
      bus.o_data_valid <= 1'b0;
`ifdef SERIALIZER_LAST_EN
      bus.o_data_last <= 1'b0;
`endif
    end else if (out_fire) begin
      sr <= sr >> OUT_WIDTH;
      cnt <= cnt + 1'b1;
      bus.o_data <= sr[OUT_WIDTH +: OUT_WIDTH];
`ifdef SERIALIZER_LAST_EN
      bus.o_data_last <= cnt == CW'(RATIO - 2);
`endif
    end
endmodule
